// File: rtl/register_file.sv
// register_file: parametrised register bank with one synchronous write port
// and two independent combinational read ports.
//
// Ports:
//   clock        rising-edge clock for all state
//   reset_n      synchronous active-low clear of every register
//   write_enable commit write_data to write_addr at the next rising edge
//   write_addr   destination register
//   write_data   data to store
//   read_addr_a  read port A select
//   read_data_a  contents of register read_addr_a (combinational)
//   read_addr_b  read port B select
//   read_data_b  contents of register read_addr_b (combinational)
//
// ZERO_REG=1 makes register 0 read as constant zero and ignore writes.
// BYPASS=1 forwards write_data to a read port selecting the register being
// legally written in the same cycle. Out-of-range addresses read 0 and
// writes to them are dropped.
module register_file #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic [ADDR_W-1:0] read_addr_a,
  output logic [WIDTH-1:0]  read_data_a,
  input  logic [ADDR_W-1:0] read_addr_b,
  output logic [WIDTH-1:0]  read_data_b
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] load_en;
  logic             write_legal;

  // One-hot write decoder; out-of-range addresses match no register, and the
  // hardwired zero register is never enabled.
  always_comb begin
    load_en = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      load_en[i] = write_enable && (write_addr == ADDR_W'(i))
                   && !(ZERO_REG && (i == 0));
    end
  end

  // A write is legal exactly when some register is enabled.
  assign write_legal = |load_en;

  // Storage: reset wins over a simultaneous write.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (load_en[i]) begin
          regs[i] <= write_data;
        end
      end
    end
  end

  // Read port A mux; unmatched (out-of-range) addresses fall through to 0.
  always_comb begin
    read_data_a = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((read_addr_a == ADDR_W'(i)) && !(ZERO_REG && (i == 0))) begin
        read_data_a = regs[i];
      end
    end
    if (BYPASS && write_legal && (read_addr_a == write_addr)) begin
      read_data_a = write_data;
    end
  end

  // Read port B mux, independent of port A.
  always_comb begin
    read_data_b = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if ((read_addr_b == ADDR_W'(i)) && !(ZERO_REG && (i == 0))) begin
        read_data_b = regs[i];
      end
    end
    if (BYPASS && write_legal && (read_addr_b == write_addr)) begin
      read_data_b = write_data;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: drives four register_file configurations from one shared
// stimulus stream and checks every read port each cycle against an
// array-based model, plus hand-computed literal expectations.
//   k=0: 32x32, ZERO_REG=1, BYPASS=1
//   k=1: 32x32, ZERO_REG=0, BYPASS=1
//   k=2: 32x32, ZERO_REG=1, BYPASS=0
//   k=3: 16-bit x 8, ADDR_W=4, ZERO_REG=1, BYPASS=1 (low address/data bits)
module tb_register_file;

  logic        clock;
  logic        reset_n;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  ra;
  logic [4:0]  rb;

  logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1, rd_a2, rd_b2;
  logic [15:0] rd_a3, rd_b3;
  logic [31:0] got_a [4];
  logic [31:0] got_b [4];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m [4][32];
  bit          model_valid = 1'b0;

  register_file #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u0 (
    .clock(clock), .reset_n(reset_n), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data),
    .read_addr_a(ra), .read_data_a(rd_a0), .read_addr_b(rb), .read_data_b(rd_b0));

  register_file #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b1)) u1 (
    .clock(clock), .reset_n(reset_n), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data),
    .read_addr_a(ra), .read_data_a(rd_a1), .read_addr_b(rb), .read_data_b(rd_b1));

  register_file #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u2 (
    .clock(clock), .reset_n(reset_n), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data),
    .read_addr_a(ra), .read_data_a(rd_a2), .read_addr_b(rb), .read_data_b(rd_b2));

  register_file #(.WIDTH(16), .DEPTH(8), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b1)) u3 (
    .clock(clock), .reset_n(reset_n), .write_enable(write_enable),
    .write_addr(write_addr[3:0]), .write_data(write_data[15:0]),
    .read_addr_a(ra[3:0]), .read_data_a(rd_a3), .read_addr_b(rb[3:0]), .read_data_b(rd_b3));

  assign got_a[0] = rd_a0;
  assign got_b[0] = rd_b0;
  assign got_a[1] = rd_a1;
  assign got_b[1] = rd_b1;
  assign got_a[2] = rd_a2;
  assign got_b[2] = rd_b2;
  assign got_a[3] = {16'h0000, rd_a3};
  assign got_b[3] = {16'h0000, rd_b3};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Configuration of each instance.
  function automatic int depth_of(int k);
    return (k == 3) ? 8 : 32;
  endfunction

  function automatic logic [31:0] mask_of(int k);
    return (k == 3) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic bit zero_of(int k);
    return k != 1;
  endfunction

  function automatic bit bypass_of(int k);
    return k != 2;
  endfunction

  function automatic int addr_of(int k, logic [4:0] a);
    return (k == 3) ? int'(a[3:0]) : int'(a);
  endfunction

  function automatic bit write_ok(int k);
    int wa;
    wa = addr_of(k, write_addr);
    return (wa < depth_of(k)) && !(zero_of(k) && wa == 0);
  endfunction

  // Value a read port must present for this configuration and address.
  function automatic logic [31:0] exp_rd(int k, logic [4:0] addr);
    int a;
    a = addr_of(k, addr);
    if (zero_of(k) && a == 0) return 32'h0;
    if (a >= depth_of(k)) return 32'h0;
    if (bypass_of(k) && write_enable && write_ok(k) && a == addr_of(k, write_addr))
      return write_data & mask_of(k);
    return m[k][a];
  endfunction

  // Model state update at each rising edge.
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++)
        for (int a = 0; a < 32; a++)
          m[k][a] = 32'h0;
      model_valid = 1'b1;
    end else if (write_enable) begin
      for (int k = 0; k < 4; k++)
        if (write_ok(k)) m[k][addr_of(k, write_addr)] = write_data & mask_of(k);
    end
  end

  // Every-cycle comparison of all read ports against the model.
  always @(negedge clock) begin
    if (model_valid && !(!reset_n && write_enable)) begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got_a[k] !== exp_rd(k, ra)) begin
          n_fail++;
          $display("FAIL model_a k=%0d addr=%0d: got %h expected %h", k, ra, got_a[k], exp_rd(k, ra));
        end
        n_checks++;
        if (got_b[k] !== exp_rd(k, rb)) begin
          n_fail++;
          $display("FAIL model_b k=%0d addr=%0d: got %h expected %h", k, rb, got_b[k], exp_rd(k, rb));
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    write_enable = 1'b1;
    write_addr   = a;
    write_data   = d;
    step();
    write_enable = 1'b0;
  endtask

  logic [31:0] wv [8];

  initial begin
    wv = '{32'h0000_000F, 32'h0000_000A, 32'h0000_0000, 32'h0000_0001,
           32'h0000_0002, 32'h0000_F000, 32'h0000_0004, 32'h0000_000B};
    reset_n = 1'b0; write_enable = 1'b0; write_addr = '0; write_data = '0;
    ra = '0; rb = '0;

    // Reset for two edges, then sweep both ports.
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i);
      step();
    end
    ra = 5'd17;
    @(negedge clock);
    check("reset_read_a", got_a[0], 32'h0);
    check("reset_read_b", got_b[1], 32'h0);

    // Write sweep to registers 1..8.
    step();
    for (int i = 0; i < 8; i++) wr(5'(i + 1), wv[i]);
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'((i + 5) % 32);
      step();
    end
    ra = 5'd6; rb = 5'd1;
    @(negedge clock);
    check("sweep_a6", got_a[0], 32'h0000_F000);
    check("sweep_b1", got_b[0], 32'h0000_000F);
    check("sweep_small_a6", got_a[3], 32'h0000_F000);
    step();
    ra = 5'd8;
    @(negedge clock);
    check("sweep_a8", got_a[0], 32'h0000_000B);
    check("small_oor_a8", got_a[3], 32'h0);

    // Zero register.
    step();
    ra = 5'd0; write_enable = 1'b1; write_addr = 5'd0; write_data = 32'hDEAD_BEEF;
    @(negedge clock);
    check("zero_in_cycle", got_a[0], 32'h0);
    check("nozero_bypass", got_a[1], 32'hDEAD_BEEF);
    step();
    write_enable = 1'b0;
    @(negedge clock);
    check("zero_after", got_a[0], 32'h0);
    check("nozero_after", got_a[1], 32'hDEAD_BEEF);

    // Bypass.
    step();
    wr(5'd5, 32'h0000_F000);
    ra = 5'd5; rb = 5'd5; write_enable = 1'b1; write_addr = 5'd5; write_data = 32'h1234_5678;
    @(negedge clock);
    check("bypass_a", got_a[0], 32'h1234_5678);
    check("bypass_b", got_b[0], 32'h1234_5678);
    check("nobypass_a", got_a[2], 32'h0000_F000);
    check("nobypass_b", got_b[2], 32'h0000_F000);
    step();
    write_enable = 1'b0;
    @(negedge clock);
    check("nobypass_after", got_a[2], 32'h1234_5678);

    // Reset colliding with a write.
    step();
    wr(5'd3, 32'h0000_0001);
    reset_n = 1'b0; write_enable = 1'b1; write_addr = 5'd3; write_data = 32'hFFFF_FFFF;
    ra = 5'd3; rb = 5'd4;
    step();
    reset_n = 1'b1; write_enable = 1'b0;
    @(negedge clock);
    check("collide_a3", got_a[0], 32'h0);
    check("collide_nobyp_a3", got_a[2], 32'h0);
    check("collide_b4", got_b[0], 32'h0);
    step();
    wr(5'd3, 32'hFFFF_FFFF);
    @(negedge clock);
    check("after_collide_a3", got_a[0], 32'hFFFF_FFFF);
    check("after_collide_small", got_a[3], 32'h0000_FFFF);

    // Back-to-back writes to one address.
    step();
    wr(5'd10, 32'h0000_0011);
    wr(5'd10, 32'h0000_0022);
    ra = 5'd10;
    @(negedge clock);
    check("b2b_last_wins", got_a[0], 32'h0000_0022);

    // Write-enable glitch between edges.
    step();
    ra = 5'd12;
    #1 write_enable = 1'b1; write_addr = 5'd12; write_data = 32'h0000_CAFE;
    #2 write_enable = 1'b0;
    @(negedge clock);
    check("glitch_a12", got_a[0], 32'h0);
    step();
    @(negedge clock);
    check("glitch_a12_later", got_a[0], 32'h0);

    // Narrow variant: in-range and out-of-range writes.
    step();
    wr(5'd7, 32'h0000_ABCD);
    wr(5'd9, 32'h0000_1111);
    ra = 5'd7; rb = 5'd9;
    @(negedge clock);
    check("small_a7", got_a[3], 32'h0000_ABCD);
    check("small_b9", got_b[3], 32'h0);
    check("wide_b9", got_b[0], 32'h0000_1111);
    step();
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
